stream_combiner: RTL and testbench

Parametrised Avalon-ST combiner: merges `CH` input streams of width `N` into one output stream using a runtime-selectable bitwise or arithmetic operation. It is the successor to the fixed two-input OR combiner, adding true per-channel ready/valid handshaking, output back-pressure holding and a channel-count parameter. It sits between Avalon-ST sources and a single Avalon-ST sink in the platform-designer fabric, ready latency 0.

---
 rtl/stream_combiner_if.sv | 22 ++
 rtl/stream_combiner.sv | 60 ++++++
 tb/tb_stream_combiner.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_combiner_if.sv
// stream_combiner_if: Avalon-ST bundle for stream_combiner (op select, CH inputs, one output, beat counter)
interface stream_combiner_if #(
  parameter int N = 32,
  parameter int CH = 2
);
  logic [1:0] op_sel;
  logic [CH-1:0][N-1:0] asi_in_data;
  logic [CH-1:0] asi_in_valid;
  logic [CH-1:0] asi_in_ready;
  logic [N-1:0] aso_out0_data;
  logic aso_out0_valid;
  logic aso_out0_ready;
  logic [15:0] fire_count;
  modport master (
    output op_sel, asi_in_data, asi_in_valid, aso_out0_ready,
    input asi_in_ready, aso_out0_data, aso_out0_valid, fire_count
  );
  modport slave (
    input op_sel, asi_in_data, asi_in_valid, aso_out0_ready,
    output asi_in_ready, aso_out0_data, aso_out0_valid, fire_count
  );
endinterface

// File: rtl/stream_combiner.sv
// stream_combiner: joins CH Avalon-ST inputs into one output via OR/AND/XOR/ADD; STREAM_COMBINER_STICKY_EN selects sample-and-hold firing
module stream_combiner #(
  parameter int N = 32,
  parameter int CH = 2
) (
  input logic clock_clk,
  input logic reset_reset,
  stream_combiner_if.slave bus
);
  logic [CH-1:0][N-1:0] hold_data_q, hold_data_d;
  logic [CH-1:0] hold_full_q, hold_full_d, cap;
  logic [N-1:0] out_data_q, out_data_d, red;
  logic out_valid_q, out_valid_d, slot_free, fire;
  logic [15:0] fire_count_q, fire_count_d;
  assign slot_free = !out_valid_q || bus.aso_out0_ready;
`ifdef STREAM_COMBINER_STICKY_EN
  assign fire = |hold_full_q && slot_free;
`else
  assign fire = &hold_full_q && slot_free;
`endif
  assign bus.asi_in_ready = {CH{!reset_reset}} & (~hold_full_q | {CH{fire}});
  assign cap = bus.asi_in_valid & bus.asi_in_ready;
  assign bus.aso_out0_data = out_data_q;
  assign bus.aso_out0_valid = out_valid_q;
  assign bus.fire_count = fire_count_q;
  // fold all held channels with the selected operation; ADD wraps at N bits
  always_comb begin
    red = (bus.op_sel == 2'd1) ? '1 : '0;
    for (int i = 0; i < CH; i++)
      red = (bus.op_sel == 2'd0) ? (red | hold_data_q[i]) :
            (bus.op_sel == 2'd1) ? (red & hold_data_q[i]) :
            (bus.op_sel == 2'd2) ? (red ^ hold_data_q[i]) : (red + hold_data_q[i]);
  end
  // capture accepted inputs, drop join flags on fire (capture wins), load or hold the output slot
  always_comb begin
    hold_data_d = hold_data_q;
    for (int i = 0; i < CH; i++)
      hold_data_d[i] = cap[i] ? bus.asi_in_data[i] : hold_data_q[i];
    hold_full_d = (hold_full_q & ~{CH{fire}}) | cap;
    out_data_d = fire ? red : out_data_q;
    out_valid_d = fire || (out_valid_q && !bus.aso_out0_ready);
    fire_count_d = fire_count_q + {15'd0, fire};
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      hold_data_q <= '0;
      hold_full_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      fire_count_q <= '0;
    end else begin
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      fire_count_q <= fire_count_d;
    end
  end
endmodule

// File: tb/tb_stream_combiner.sv
// tb_stream_combiner: directed and random checks of stream_combiner against a queue-based transaction model
module tb_stream_combiner;
  localparam int N = 8;
  localparam int CH = 4;
  logic clk = 0;
  logic rst = 1;
  stream_combiner_if #(.N(N), .CH(CH)) bus ();
  stream_combiner #(.N(N), .CH(CH)) dut (.clock_clk(clk), .reset_reset(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  int nvec = 0;
  int nerr = 0;
  int nbeats = 0;
  logic [N-1:0] q [CH][$];
  logic [CH-1:0] src_valid;
  logic [N-1:0] src_data [CH];
  int mode = 0;
  int vrate = 70;
  int rrate = 70;
  bit sb_on = 1;
  logic [1:0] exp_op = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_op(input logic [1:0] op, input logic [N-1:0] v [CH]);
    int unsigned sum;
    logic [N-1:0] r;
    sum = 0;
    r = (op == 2'd1) ? '1 : '0;
    foreach (v[i]) begin
      sum += v[i];
      case (op)
        2'd0: r |= v[i];
        2'd1: r &= v[i];
        2'd2: r ^= v[i];
        default: ;
      endcase
    end
    return (op == 2'd3) ? sum[N-1:0] : r;
  endfunction

  function automatic logic [N-1:0] peek_exp();
    logic [N-1:0] v [CH];
    for (int i = 0; i < CH; i++) v[i] = q[i][0];
    return ref_op(exp_op, v);
  endfunction

  function automatic int queued();
    int s;
    s = 0;
    for (int i = 0; i < CH; i++) s += q[i].size();
    return s;
  endfunction

  task automatic drive();
    bus.asi_in_valid = src_valid;
    for (int i = 0; i < CH; i++) bus.asi_in_data[i] = src_data[i];
  endtask

  task automatic cycle();
    logic [CH-1:0] hs;
    logic [N-1:0] v [CH];
    @(negedge clk);
    hs = bus.asi_in_valid & bus.asi_in_ready;
    if (sb_on && bus.aso_out0_valid && bus.aso_out0_ready) begin
      int mn;
      mn = q[0].size();
      for (int i = 1; i < CH; i++) if (q[i].size() < mn) mn = q[i].size();
      chk("beat_has_inputs", mn > 0, 1);
      if (mn > 0) begin
        for (int i = 0; i < CH; i++) v[i] = q[i].pop_front();
        chk("beat_data", bus.aso_out0_data, ref_op(exp_op, v));
      end
      nbeats++;
    end
    for (int i = 0; i < CH; i++) if (hs[i]) q[i].push_back(bus.asi_in_data[i]);
    @(posedge clk);
    #1;
    for (int i = 0; i < CH; i++) begin
      if (mode == 0 && hs[i]) src_valid[i] = 1'b0;
      if (mode == 1 && hs[i]) src_data[i] = N'($urandom);
      if (mode == 2 && (hs[i] || !src_valid[i])) begin
        src_valid[i] = ($urandom_range(99) < vrate);
        src_data[i] = N'($urandom);
      end
    end
    if (mode == 2) bus.aso_out0_ready = ($urandom_range(99) < rrate);
    drive();
  endtask

  task automatic do_reset();
    rst = 1;
    mode = 0;
    src_valid = '0;
    drive();
    bus.aso_out0_ready = 1;
    for (int i = 0; i < CH; i++) q[i].delete();
    nbeats = 0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < CH; i++) src_data[i] = '0;
    src_valid = '0;
    bus.op_sel = 0;
    bus.aso_out0_ready = 1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.asi_in_ready, 0);
    chk("rst_valid", bus.aso_out0_valid, 0);
    chk("rst_data", bus.aso_out0_data, 0);
    chk("rst_count", bus.fire_count, 0);
    rst = 0;
    #1;
    chk("ready_after_release", bus.asi_in_ready, 4'hF);
    // ADD wraps modulo 2^N; latency one edge after capture
    bus.op_sel = 3;
    exp_op = 3;
    src_data = '{8'h80, 8'h80, 8'h01, 8'h02};
    src_valid = '1;
    drive();
    cycle();
    chk("add_not_yet", bus.aso_out0_valid, 0);
    cycle();
    chk("add_valid", bus.aso_out0_valid, 1);
    chk("add_data", bus.aso_out0_data, 8'h03);
    chk("add_count", bus.fire_count, 1);
    repeat (2) cycle();
    // AND reduction
    bus.op_sel = 1;
    exp_op = 1;
    src_data = '{8'hFF, 8'h0F, 8'h3C, 8'hFF};
    src_valid = '1;
    drive();
    repeat (2) cycle();
    chk("and_data", bus.aso_out0_data, 8'h0C);
    repeat (2) cycle();
    // join: ch0 early, others arrive at cycle 5
    bus.op_sel = 2;
    exp_op = 2;
    src_data = '{8'h11, 8'h22, 8'h44, 8'h88};
    src_valid = 4'b0001;
    drive();
    for (int c = 1; c <= 5; c++) begin
      cycle();
      chk("join_rdy0_low", bus.asi_in_ready[0], 0);
      chk("join_no_beat", bus.aso_out0_valid, 0);
    end
    src_valid = 4'b1110;
    drive();
    chk("join_rdy0_still_low", bus.asi_in_ready[0], 0);
    cycle();
    chk("join_no_beat_c6", bus.aso_out0_valid, 0);
    cycle();
    chk("join_beat", bus.aso_out0_valid, 1);
    chk("join_data", bus.aso_out0_data, 8'hFF);
    cycle();
    chk("join_single_beat", bus.aso_out0_valid, 0);
    // back-pressure for 10 cycles with continuous sources
    bus.op_sel = 0;
    exp_op = 0;
    mode = 1;
    bus.aso_out0_ready = 0;
    src_valid = '1;
    for (int i = 0; i < CH; i++) src_data[i] = N'($urandom);
    drive();
    repeat (2) cycle();
    for (int c = 0; c < 8; c++) begin
      cycle();
      chk("bp_valid_held", bus.aso_out0_valid, 1);
      chk("bp_data_held", bus.aso_out0_data, peek_exp());
      chk("bp_ready_low", bus.asi_in_ready, 0);
    end
    bus.aso_out0_ready = 1;
    repeat (10) cycle();
    src_valid = '0;
    drive();
    mode = 0;
    repeat (4) cycle();
    chk("bp_no_loss", queued(), 0);
    chk("bp_count", bus.fire_count, 16'(nbeats));
    // continuous streaming, 100 beats in 101 cycles
    do_reset();
    bus.op_sel = 3;
    exp_op = 3;
    mode = 1;
    src_valid = '1;
    for (int i = 0; i < CH; i++) src_data[i] = N'($urandom);
    drive();
    repeat (101) cycle();
    chk("stream_fire_count", bus.fire_count, 100);
    chk("stream_beats_seen", nbeats, 99);
    src_valid = '0;
    drive();
    mode = 0;
    repeat (3) cycle();
    chk("stream_all_beats", nbeats, 101);
    // random valids and sink stalls, each operation
    for (int op = 0; op < 4; op++) begin
      bus.op_sel = 2'(op);
      exp_op = 2'(op);
      vrate = $urandom_range(100, 50);
      rrate = $urandom_range(100, 40);
      mode = 2;
      repeat (300) cycle();
      mode = 0;
      src_valid = '1;
      for (int i = 0; i < CH; i++) src_data[i] = N'($urandom);
      bus.aso_out0_ready = 1;
      drive();
      repeat (10) cycle();
      chk("rand_drained", bus.aso_out0_valid, 0);
    end
    chk("rand_count", bus.fire_count, 16'(nbeats));
    // reset mid-stream with output pending
    bus.op_sel = 0;
    exp_op = 0;
    mode = 1;
    src_valid = '1;
    bus.aso_out0_ready = 0;
    drive();
    repeat (4) cycle();
    chk("pre_rst_pending", bus.aso_out0_valid, 1);
    rst = 1;
    #1;
    chk("async_rst_valid", bus.aso_out0_valid, 0);
    chk("async_rst_data", bus.aso_out0_data, 0);
    chk("async_rst_ready", bus.asi_in_ready, 0);
    chk("async_rst_count", bus.fire_count, 0);
    mode = 0;
    src_valid = '0;
    drive();
    for (int i = 0; i < CH; i++) q[i].delete();
    nbeats = 0;
    @(posedge clk);
    #1;
    rst = 0;
    bus.aso_out0_ready = 1;
    src_valid = 4'b0010;
    src_data[1] = 8'h05;
    drive();
`ifdef STREAM_COMBINER_STICKY_EN
    sb_on = 0;
    repeat (2) cycle();
    chk("sticky_valid", bus.aso_out0_valid, 1);
    chk("sticky_data", bus.aso_out0_data, 8'h05);
`else
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("post_rst_no_beat", bus.aso_out0_valid, 0);
    end
    chk("post_rst_ch1_waits", bus.asi_in_ready[1], 0);
    chk("post_rst_count", bus.fire_count, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
